lcd_saida_dados: RTL
====================

// Module: lcd_saida_dados
// PURPOSE
//  Output-side counterpart of the switch/enter input port: on the processor OUT
//  handshake, shows a 32-bit signed result as decimal text on LCD line 1.
//  Sits between the UC/mux_Mem data path and the HD44780 pins (write-only, RW=0).
//  Owns LCD power-up init. Holds busy so the UC can stall a following OUT.
// PARAMETERS
//  T_PWRUP  1000000  cycles to wait after reset before the first command (20 ms @ 50 MHz)
//  T_EN     25       cycles LCD_EN is held high per byte (500 ns)
//  T_CMD    2500     post-byte wait for normal commands and characters (50 us)
//  T_CLR    100000   post-byte wait after the 0x01 clear command (2 ms)
// PORTS
//  clock     in   1   system clock
//  reset     in   1   asynchronous, active-high
//  out_valid in   1   one-cycle strobe from the UC: dado is valid
//  dado      in   32  two's-complement value to display
//  busy      out  1   high while initialising, converting or writing; strobes are ignored
//  LCD_DATA  out  8   LCD data bus
//  LCD_RS    out  1   0 = command, 1 = character
//  LCD_RW    out  1   tied 0
//  LCD_EN    out  1   LCD enable strobe
// BEHAVIOUR
//  Reset (async): LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, busy=1. FSM goes to PWRUP.
//   Reset mid-operation aborts any byte and restarts the full init sequence.
//  FSM states: PWRUP, INIT, IDLE, CONV, LINE, BYTE_SETUP, BYTE_EN, BYTE_WAIT.
//  PWRUP: count T_PWRUP cycles, then go to INIT.
//  INIT: send 0x38, 0x0C, 0x06, 0x01 in that order as commands (RS=0), then go to IDLE.
//  IDLE: busy=0. If out_valid=1: latch dado, set busy=1 on the next edge, go to CONV.
//   out_valid in any other state is dropped and no pending flag is kept.
//  CONV: sign = dado[31]; magnitude = sign ? -dado : dado as 32-bit unsigned
//   (0x80000000 gives 2147483648).
//   Shift-add-3 (double dabble) into 10 BCD digits takes exactly 32 cycles, one bit per cycle.
//  LINE: send command 0x80, then 16 characters:
//   col 0: '-' (0x2D) if sign, else ' ' (0x20);
//   cols 1..10: digits, most significant first, as 0x30+d;
//    leading zeros are spaces; col 10 always shows a digit, so 0 displays "0";
//   cols 11..15: ' '.
//   After the last byte, go to IDLE.
//  Byte write, shared sub-sequence:
//   BYTE_SETUP: drive RS and DATA for 1 cycle.
//   BYTE_EN: EN=1 for T_EN cycles.
//   BYTE_WAIT: EN=0 for T_CMD cycles, or T_CLR if the byte was command 0x01.
//   RS and DATA stay stable from SETUP until the end of WAIT.
//  Busy timing: busy falls in the cycle IDLE is entered. Minimum OUT-to-ready latency is
//   1 + 32 + 17*(1+T_EN+T_CMD) cycles.
//  Only line 1 is written. The display is not cleared per value; the 16-column overwrite
//   replaces the previous text.
// TESTING (bench overrides T_PWRUP=20, T_EN=2, T_CMD=4, T_CLR=8)
//  reset, then release -> bytes 0x38,0x0C,0x06,0x01 with RS=0; after each byte EN stays
//   low 4 cycles (8 cycles after 0x01); busy falls after the 0x01 wait.
//  out_valid with dado=123 -> 0x80 (RS=0), then RS=1 chars " " x8,"1","2","3"," " x5.
//  dado=0xFFFFFFFF -> col0 '-', cols 1..9 ' ', col10 '1'.
//  dado=0x80000000 -> "-2147483648" followed by 5 spaces.
//  dado=0 -> only col 10 is '0'. A second out_valid while busy=1 -> ignored, no extra bytes.
//  reset asserted during BYTE_EN of a char -> EN falls immediately; after release the
//   full init sequence replays from PWRUP.

Source files
------------

// File: rtl/lcd_saida_dados_if.sv
// lcd_saida_dados_if
//   Groups the processor OUT handshake and the HD44780 pin bundle of the
//   decimal LCD output port.
//   out_valid : one-cycle strobe from the UC, dado is valid
//   dado      : 32-bit two's-complement value to display
//   busy      : port is initialising, converting or writing; strobes ignored
//   LCD_DATA  : LCD data bus
//   LCD_RS    : 0 = command, 1 = character
//   LCD_RW    : always 0 (write-only)
//   LCD_EN    : LCD enable strobe
//   master = UC / board side, slave = lcd_saida_dados.
interface lcd_saida_dados_if;
  logic        out_valid;
  logic [31:0] dado;
  logic        busy;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_EN;

  modport master (
    output out_valid, dado,
    input  busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );

  modport slave (
    input  out_valid, dado,
    output busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
  );
endinterface

// File: rtl/lcd_saida_dados.sv
// lcd_saida_dados
//   Output-side counterpart of the switch/enter input port. On an OUT strobe
//   the 32-bit signed value is converted to decimal and written as 16
//   characters on LCD line 1. Also performs the LCD power-up initialisation.
//   clock : system clock
//   reset : asynchronous, active-high; restarts the whole init sequence
//   bus   : lcd_saida_dados_if.slave (handshake + HD44780 pins)
//   T_PWRUP / T_EN / T_CMD / T_CLR : power-up wait, EN high time, post-byte
//   wait for ordinary bytes, post-byte wait after the clear command.
module lcd_saida_dados #(
  parameter int unsigned T_PWRUP = 1000000,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 100000
) (
  input logic             clock,
  input logic             reset,
  lcd_saida_dados_if.slave bus
);

  typedef enum logic [2:0] {
    PWRUP, INIT, IDLE, CONV, LINE, BYTE_SETUP, BYTE_EN, BYTE_WAIT
  } state_t;

  localparam logic [31:0] PwrupLast = 32'(T_PWRUP - 1);
  localparam logic [31:0] EnLast    = 32'(T_EN - 1);
  localparam logic [31:0] CmdLast   = 32'(T_CMD - 1);
  localparam logic [31:0] ClrLast   = 32'(T_CLR - 1);

  state_t      state_q, state_d;
  state_t      seq_q, seq_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic        sign_q, sign_d;
  logic [4:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;

  logic [31:0] waitLast;
  logic [8:0]  nextByte;
  logic        lastByte;
  logic [39:0] bcdAdj;

  // Command bytes of the init sequence: 8-bit 2-line, display on, entry
  // increment, clear.
  function automatic logic [7:0] initByte(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'h38;
      5'd1:    return 8'h0C;
      5'd2:    return 8'h06;
      5'd3:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx of the line sequence as {RS, DATA}: 0 is the set-DDRAM command,
  // 1 is the sign column, 2..11 the ten digits (leading zeros blanked except
  // the units digit), the rest trailing spaces.
  function automatic logic [8:0] lineByte(input logic [4:0] idx, input logic sign,
                                          input logic [39:0] bcd);
    logic [8:0] b;
    logic [3:0] dig;
    logic       lead;
    b    = {1'b1, 8'h20};
    lead = 1'b1;
    if (idx == 5'd0) begin
      b = {1'b0, 8'h80};
    end else if (idx == 5'd1) begin
      b = sign ? {1'b1, 8'h2D} : {1'b1, 8'h20};
    end else if (idx <= 5'd11) begin
      for (int k = 0; k < 10; k++) begin
        dig = bcd[39-4*k -: 4];
        if (dig != 4'd0) lead = 1'b0;
        if (k == int'(idx) - 2 && (!lead || k == 9)) b = {1'b1, 4'h3, dig};
      end
    end
    return b;
  endfunction

  // Add-3 correction of every BCD digit that is 5 or more before the shift.
  function automatic logic [39:0] addThree(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int k = 0; k < 10; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // State and datapath registers; reset aborts any byte in flight and
  // drops the LCD pins to their idle levels immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PWRUP;
      seq_q   <= INIT;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. seq_q remembers which byte sequence (INIT or LINE) the
  // shared byte sub-sequence is serving. The next byte of a sequence is
  // loaded on the last BYTE_WAIT cycle, so consecutive bytes follow each
  // other with no idle cycle; the line's first command is loaded on the
  // last conversion cycle for the same reason.
  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    sign_d   = sign_q;
    idx_d    = idx_q;
    rs_d     = rs_q;
    data_d   = data_q;
    waitLast = (!rs_q && data_q == 8'h01) ? ClrLast : CmdLast;
    nextByte = (seq_q == INIT) ? {1'b0, initByte(5'(idx_q + 5'd1))}
                               : lineByte(5'(idx_q + 5'd1), sign_q, bcd_q);
    lastByte = (seq_q == INIT) ? (idx_q == 5'd3) : (idx_q == 5'd16);
    bcdAdj   = addThree(bcd_q);

    case (state_q)
      PWRUP: begin
        if (cnt_q == PwrupLast) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      INIT: begin
        seq_d   = INIT;
        idx_d   = '0;
        rs_d    = 1'b0;
        data_d  = initByte(5'd0);
        cnt_d   = '0;
        state_d = BYTE_SETUP;
      end
      IDLE: begin
        if (bus.out_valid) begin
          sign_d  = bus.dado[31];
          bin_d   = bus.dado[31] ? (~bus.dado + 32'd1) : bus.dado;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcdAdj[38:0], bin_q[31]};
        bin_d = {bin_q[30:0], 1'b0};
        if (cnt_q == 32'd31) begin
          seq_d   = LINE;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = 8'h80;
          cnt_d   = '0;
          state_d = BYTE_SETUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BYTE_SETUP: begin
        cnt_d   = '0;
        state_d = BYTE_EN;
      end
      BYTE_EN: begin
        if (cnt_q == EnLast) begin
          cnt_d   = '0;
          state_d = BYTE_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BYTE_WAIT: begin
        if (cnt_q == waitLast) begin
          cnt_d = '0;
          if (lastByte) begin
            state_d = IDLE;
          end else begin
            idx_d          = 5'(idx_q + 5'd1);
            {rs_d, data_d} = nextByte;
            state_d        = BYTE_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  // EN is registered so it is glitch-free and cleared by reset at once.
  assign en_d = (state_d == BYTE_EN);

  assign bus.busy     = (state_q != IDLE);
  assign bus.LCD_DATA = data_q;
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_EN   = en_q;

endmodule
